// File: rtl/rf_write_scheduler.sv
// Register-file write-port arbiter: writeback passes straight through, long-latency results queue and drain on idle cycles.
// Optional post-reset clear sweep of x1..x31 is built only when RF_CLEAR_ON_RESET_EN is defined.
module rf_write_scheduler #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        wb_hold,
  output logic        init_busy,
  input  logic [4:0]  q_a1,
  input  logic [4:0]  q_a2,
  output logic        q_hit,
  output logic        rf_we,
  output logic [4:0]  rf_a3,
  output logic [31:0] rf_wd,
  output logic [0:0]  state_dbg
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Handshake: an lu result transfers at the posedge where lu_valid and lu_ready
  // are both high; the producer holds lu_* stable while lu_ready is low.
  // Writeback has no handshake and is always accepted in RUN.

  logic [0:0]    state;
  logic          ent_valid [DEPTH];
  logic [4:0]    ent_rd    [DEPTH];
  logic [31:0]   ent_data  [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve;

  logic run;
  logic head_present;
  logic head_valid;
  logic push;
  logic pop;
  logic drain;
  logic squash;

`ifdef RF_CLEAR_ON_RESET_EN
  logic [4:0] init_ctr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_INIT;
      init_ctr <= 5'd1;
    end else if (state == ST_INIT) begin
      if (init_ctr == 5'd31) begin
        state <= ST_RUN;
      end else begin
        init_ctr <= init_ctr + 5'd1;
      end
    end
  end
`else
  assign state = ST_RUN;
`endif

  assign state_dbg = state;
  assign init_busy = (state == ST_INIT);
  assign run       = (state == ST_RUN);

  assign head_present = run && (count != '0);
  assign head_valid   = head_present && ent_valid[rptr];
  assign lu_ready     = run && (count < CW'(DEPTH));
  // lu_rd == 0 is consumed by the handshake but never stored
  assign push         = lu_valid && lu_ready && (lu_rd != 5'd0);
  // A squashed head leaves even while writeback owns the port
  assign pop          = head_present && (!ent_valid[rptr] || !wb_we);
  assign drain        = pop && ent_valid[rptr];
  assign squash       = run && wb_we && (wb_rd != 5'd0);

  always_comb begin
    rf_we = 1'b0;
    rf_a3 = 5'd0;
    rf_wd = 32'd0;
`ifdef RF_CLEAR_ON_RESET_EN
    if (state == ST_INIT) begin
      rf_we = 1'b1;
      rf_a3 = init_ctr;
      rf_wd = 32'd0;
    end else
`endif
    if (run && wb_we) begin
      rf_we = 1'b1;
      rf_a3 = wb_rd;
      rf_wd = wb_data;
    end else if (drain) begin
      rf_we = 1'b1;
      rf_a3 = ent_rd[rptr];
      rf_wd = ent_data[rptr];
    end
  end

  always_comb begin
    q_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (run && ent_valid[i]) begin
        if ((q_a1 != 5'd0) && (ent_rd[i] == q_a1)) q_hit = 1'b1;
        if ((q_a2 != 5'd0) && (ent_rd[i] == q_a2)) q_hit = 1'b1;
      end
    end
  end

  // Valid bit doubles as "slot occupied and still owed a write"
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_valid[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (pop && (rptr == AW'(i))) begin
          ent_valid[i] <= 1'b0;
        end
        if (push && (wptr == AW'(i))) begin
          ent_valid[i] <= !(squash && (wb_rd == lu_rd));
          ent_rd[i]    <= lu_rd;
          ent_data[i]  <= lu_data;
        end else if (squash && ent_valid[i] && (ent_rd[i] == wb_rd)) begin
          ent_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      rptr  <= rptr + AW'(pop);
      wptr  <= wptr + AW'(push);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // starve saturates at STARVE_MAX; wb_hold follows one cycle later and
  // releases one cycle after the head leaves
  always_ff @(posedge clk) begin
    if (reset) begin
      starve  <= '0;
      wb_hold <= 1'b0;
    end else begin
      if (head_valid && wb_we) begin
        if (starve != SW'(STARVE_MAX)) starve <= starve + SW'(1);
      end else begin
        starve <= '0;
      end
      if (pop) begin
        wb_hold <= 1'b0;
      end else if (starve == SW'(STARVE_MAX)) begin
        wb_hold <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Bench for rf_write_scheduler: directed scenarios then random traffic, checked against a queue-based model.
module tb_rf_write_scheduler;
  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        wb_hold;
  logic        init_busy;
  logic [4:0]  q_a1;
  logic [4:0]  q_a2;
  logic        q_hit;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic [0:0]  state_dbg;

  rf_write_scheduler #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .wb_hold(wb_hold), .init_busy(init_busy),
    .q_a1(q_a1), .q_a2(q_a2), .q_hit(q_hit),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        vld;
    bit [4:0]  rd;
    bit [31:0] data;
  } ent_t;

  ent_t mq[$];
  bit   m_init;
  int   m_ctr;
  int   m_blocked;
  bit   m_hold;
  bit   acc;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    mq.delete();
`ifdef RF_CLEAR_ON_RESET_EN
    m_init = 1'b1;
`else
    m_init = 1'b0;
`endif
    m_ctr     = 1;
    m_blocked = 0;
    m_hold    = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    reset    = 1'b1;
    wb_we    = 1'b0;
    lu_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // One clock cycle: inputs are already driven; check at negedge, then advance the model.
  task automatic step();
    bit        e_we, e_ready, e_hit, e_busy, head_vld, popped;
    bit [4:0]  e_a3;
    bit [31:0] e_wd;
    int        prev;
    ent_t      ne;
    @(negedge clk);
    e_a3 = '0;
    e_wd = '0;
    e_hit = 1'b0;
    if (m_init) begin
      e_we = 1'b1; e_a3 = 5'(m_ctr); e_wd = 32'd0;
      e_ready = 1'b0; e_busy = 1'b1;
    end else begin
      e_busy  = 1'b0;
      e_ready = (mq.size() < DEPTH);
      foreach (mq[i]) begin
        if (mq[i].vld && (((q_a1 != 0) && (mq[i].rd == q_a1)) || ((q_a2 != 0) && (mq[i].rd == q_a2))))
          e_hit = 1'b1;
      end
      if (wb_we) begin
        e_we = 1'b1; e_a3 = wb_rd; e_wd = wb_data;
      end else if (mq.size() > 0 && mq[0].vld) begin
        e_we = 1'b1; e_a3 = mq[0].rd; e_wd = mq[0].data;
      end else begin
        e_we = 1'b0;
      end
    end
    chk("rf_we", 32'(rf_we), 32'(e_we));
    if (e_we) begin
      chk("rf_a3", 32'(rf_a3), 32'(e_a3));
      chk("rf_wd", rf_wd, e_wd);
    end
    chk("lu_ready", 32'(lu_ready), 32'(e_ready));
    chk("q_hit", 32'(q_hit), 32'(e_hit));
    chk("wb_hold", 32'(wb_hold), 32'(m_hold));
    chk("init_busy", 32'(init_busy), 32'(e_busy));
    chk("state", 32'(state_dbg), 32'(!m_init));

    acc = lu_valid && e_ready;
    if (m_init) begin
      if (m_ctr == 31) m_init = 1'b0;
      else m_ctr++;
    end else begin
      head_vld  = (mq.size() > 0) && mq[0].vld;
      popped    = (mq.size() > 0) && (!mq[0].vld || !wb_we);
      prev      = m_blocked;
      m_hold    = popped ? 1'b0 : ((prev >= SMAX) ? 1'b1 : m_hold);
      m_blocked = (head_vld && wb_we) ? prev + 1 : 0;
      if (popped) void'(mq.pop_front());
      if (acc && lu_rd != 0) begin
        ne.vld = 1'b1; ne.rd = lu_rd; ne.data = lu_data;
        mq.push_back(ne);
      end
      if (wb_we && wb_rd != 0) begin
        foreach (mq[i]) if (mq[i].rd == wb_rd) mq[i].vld = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit [4:0] prod_rd [3];
    int       idx;
    reset = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_data = '0; q_a1 = '0; q_a2 = '0;
    do_reset(2);

`ifdef RF_CLEAR_ON_RESET_EN
    // Sweep must ignore writeback and refuse lu traffic
    for (int i = 0; i < 31; i++) begin
      wb_we = 1'($urandom_range(0, 1)); wb_rd = 5'($urandom_range(1, 31)); wb_data = $urandom;
      lu_valid = 1'b1; lu_rd = 5'd9; lu_data = $urandom;
      step();
    end
    wb_we = 1'b0; lu_valid = 1'b0;
`endif
    step();

    // Single long-latency result drains one cycle after its push
    lu_valid = 1'b1; lu_rd = 5'd5; lu_data = 32'hDEADBEEF; q_a1 = 5'd5;
    step();
    lu_valid = 1'b0;
    step();
    step();

    // Writeback to the same rd squashes the buffered entry
    lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h7777_7777;
    step();
    lu_valid = 1'b0; wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h1234_5678; q_a1 = 5'd7;
    step();
    wb_we = 1'b0;
    step();
    step();

    // Starvation: writeback every cycle, producer tries three results
    prod_rd[0] = 5'd3; prod_rd[1] = 5'd4; prod_rd[2] = 5'd6;
    idx = 0;
    wb_we = 1'b1; wb_rd = 5'd10; q_a1 = 5'd3; q_a2 = 5'd6;
    for (int c = 0; c < 10; c++) begin
      wb_data  = $urandom;
      lu_valid = (idx < 3);
      lu_rd    = prod_rd[idx % 3];
      lu_data  = 32'hA000_0000 + 32'(idx);
      step();
      if (acc) idx++;
    end
    chk("accepted_while_blocked", 32'(idx), 32'd2);
    chk("hold_after_starve", 32'(wb_hold), 32'd1);
    wb_we = 1'b0;
    for (int c = 0; c < 8; c++) begin
      lu_valid = (idx < 3);
      lu_rd    = prod_rd[idx % 3];
      lu_data  = 32'hA000_0000 + 32'(idx);
      step();
      if (acc) idx++;
    end
    lu_valid = 1'b0;

    // rd=0 result is consumed but never written
    lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'hFFFF_0000; q_a1 = 5'd0; q_a2 = 5'd0;
    step();
    lu_valid = 1'b0;
    step();
    step();

    // Reset with two entries buffered loses them
    wb_we = 1'b1; wb_rd = 5'd9; wb_data = 32'h5;
    lu_valid = 1'b1; lu_rd = 5'd11; lu_data = 32'h11;
    step();
    lu_rd = 5'd12; lu_data = 32'h12;
    step();
    lu_valid = 1'b0; q_a1 = 5'd11; q_a2 = 5'd12;
    step();
    do_reset(1);
    for (int c = 0; c < 36; c++) begin
      wb_we = 1'b0;
      step();
    end

    // Random traffic with small register range to provoke collisions
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset(1);
      end else begin
        wb_we    = m_hold ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 99) < 45);
        wb_rd    = 5'($urandom_range(0, 7));
        wb_data  = $urandom;
        lu_valid = 1'($urandom_range(0, 1));
        lu_rd    = 5'($urandom_range(0, 7));
        lu_data  = $urandom;
        q_a1     = 5'($urandom_range(0, 7));
        q_a2     = 5'($urandom_range(0, 7));
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
